// File: rtl/pipelined_add_sub.sv
// Purpose     : WIDTH-bit two's-complement adder/subtractor split into CHUNK-bit
//               ripple segments, one register stage per segment.
// Latency     : STAGES = WIDTH/CHUNK cycles; one operation accepted per clock.
// Backpressure: none; a valid bit travels with each operation, bubbles hold outputs.
//
// Ports
//   iClk    clock, rising edge
//   iRst    synchronous active-high reset; clears every register
//   iValid  operation present this cycle
//   iSub    0 = A + B + iC, 1 = A - B - iC
//   iA, iB  operands (WIDTH bits)
//   iC      carry-in (add) / borrow-in (subtract)
//   oValid  result present this cycle
//   oS      result, modulo 2^WIDTH
//   oC      carry out of the MSB (subtract: 1 = no borrow)
//   oOv     signed overflow
//   oZ      oS == 0
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic             iSub,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             oValid,
    output logic [WIDTH-1:0] oS,
    output logic             oC,
    output logic             oOv,
    output logic             oZ
);

    localparam int STAGES = WIDTH / CHUNK;
    // Number of intermediate (non-output) register stages; kept at least 1 so
    // the arrays below stay legal when the block collapses to a single stage.
    localparam int NMID   = (STAGES > 1) ? STAGES - 1 : 1;

    if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_param
        $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
    end

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

    // Ripple of CHUNK full-adder cells.
    // Returns {carry out of chunk MSB, carry into chunk MSB, chunk sum}; the
    // middle bit is only consumed by the final stage for signed overflow.
    function automatic logic [CHUNK+1:0] ripple_chunk(input logic [CHUNK-1:0] a,
                                                      input logic [CHUNK-1:0] b,
                                                      input logic             ci);
        logic [CHUNK:0]   cy;
        logic [CHUNK-1:0] s;
        logic [1:0]       fa;
        cy[0] = ci;
        s     = '0;
        for (int i = 0; i < CHUNK; i++) begin
            fa        = full_add(a[i], b[i], cy[i]);
            s[i]      = fa[0];
            cy[i+1]   = fa[1];
        end
        return {cy[CHUNK], cy[CHUNK-1], s};
    endfunction

    // Intermediate stage k holds an operation whose chunks 0..k are finished.
    // The upper chunks of mid_a/mid_b act as the operand skew lines (chunk j
    // waits j cycles before its adder uses it); the finished lower chunks of
    // mid_s act as the deskew lines so every chunk leaves together. Consumed
    // operand chunks and not-yet-computed sum chunks are never read.
    logic [NMID-1:0]            mid_vld_q, mid_vld_d;
    logic [NMID-1:0]            mid_cy_q,  mid_cy_d;
    logic [NMID-1:0][WIDTH-1:0] mid_a_q,   mid_a_d;
    logic [NMID-1:0][WIDTH-1:0] mid_b_q,   mid_b_d;
    logic [NMID-1:0][WIDTH-1:0] mid_s_q,   mid_s_d;

    // Final stage doubles as the output register.
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_s_q,   out_s_d;
    logic             out_c_q,   out_c_d;
    logic             out_ov_q,  out_ov_d;
    logic             out_z_q,   out_z_d;

    // Per-stage working values, reused for every stage in the loop below.
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic             in_v;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] nxt_s;
    logic [CHUNK+1:0] rc;
    int               kp;
    int               kc;

    always_comb begin
        mid_vld_d = '0;
        mid_cy_d  = mid_cy_q;
        mid_a_d   = mid_a_q;
        mid_b_d   = mid_b_q;
        mid_s_d   = mid_s_q;
        out_vld_d = 1'b0;
        out_s_d   = out_s_q;
        out_c_d   = out_c_q;
        out_ov_d  = out_ov_q;
        out_z_d   = out_z_q;

        // Subtract is A + ~B + 1 with the borrow-in folded into the carry-in:
        // iC=1 in subtract mode removes the +1, giving A - B - 1.
        b_eff = iSub ? ~iB : iB;
        cin   = iC ^ iSub;

        in_v  = 1'b0;
        in_a  = '0;
        in_b  = '0;
        in_c  = 1'b0;
        in_s  = '0;
        nxt_s = '0;
        rc    = '0;
        kp    = 0;
        kc    = 0;

        for (int k = 0; k < STAGES; k++) begin
            // Clamped indices keep every select in range for any STAGES.
            kp = (k > 0) ? k - 1 : 0;
            kc = (k < NMID) ? k : 0;

            if (k == 0) begin
                in_v = iValid;
                in_a = iA;
                in_b = b_eff;
                in_c = cin;
                in_s = '0;
            end else begin
                in_v = mid_vld_q[kp];
                in_a = mid_a_q[kp];
                in_b = mid_b_q[kp];
                in_c = mid_cy_q[kp];
                in_s = mid_s_q[kp];
            end

            rc    = ripple_chunk(in_a[k*CHUNK +: CHUNK], in_b[k*CHUNK +: CHUNK], in_c);
            nxt_s = in_s;
            nxt_s[k*CHUNK +: CHUNK] = rc[CHUNK-1:0];

            if (k < STAGES - 1) begin
                // Valid always advances; data only loads behind a valid bit.
                mid_vld_d[kc] = in_v;
                if (in_v) begin
                    mid_a_d[kc]  = in_a;
                    mid_b_d[kc]  = in_b;
                    mid_cy_d[kc] = rc[CHUNK+1];
                    mid_s_d[kc]  = nxt_s;
                end
            end else begin
                out_vld_d = in_v;
                if (in_v) begin
                    out_s_d  = nxt_s;
                    out_c_d  = rc[CHUNK+1];
                    // Overflow: carry into the MSB differs from carry out of it.
                    out_ov_d = rc[CHUNK+1] ^ rc[CHUNK];
                    out_z_d  = ~|nxt_s;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            mid_vld_q <= '0;
            mid_cy_q  <= '0;
            mid_a_q   <= '0;
            mid_b_q   <= '0;
            mid_s_q   <= '0;
            out_vld_q <= 1'b0;
            out_s_q   <= '0;
            out_c_q   <= 1'b0;
            out_ov_q  <= 1'b0;
            out_z_q   <= 1'b0;
        end else begin
            mid_vld_q <= mid_vld_d;
            mid_cy_q  <= mid_cy_d;
            mid_a_q   <= mid_a_d;
            mid_b_q   <= mid_b_d;
            mid_s_q   <= mid_s_d;
            out_vld_q <= out_vld_d;
            out_s_q   <= out_s_d;
            out_c_q   <= out_c_d;
            out_ov_q  <= out_ov_d;
            out_z_q   <= out_z_d;
        end
    end

    assign oValid = out_vld_q;
    assign oS     = out_s_q;
    assign oC     = out_c_q;
    assign oOv    = out_ov_q;
    assign oZ     = out_z_q;

endmodule
